// File: rtl/branch_redirect_controller_if.sv
// Bundles the branch-resolution inputs, the fetch redirect handshake and pipeline control.
// Optional stats counters appear only when BRANCH_STATS_EN is defined.
interface branch_redirect_controller_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  exValid;
    logic                  exIsBranch;
    logic                  exTaken;
    logic [ADDR_WIDTH-1:0] exTarget;
    logic [ADDR_WIDTH-1:0] exPc;
    logic                  exPredTaken;
    logic [ADDR_WIDTH-1:0] exPredTarget;
    logic                  redirectReady;
    logic                  redirectValid;
    logic [ADDR_WIDTH-1:0] redirectPc;
    logic                  flush;
    logic                  stall;
    logic                  misalignValid;
    logic [ADDR_WIDTH-1:0] misalignPc;
`ifdef BRANCH_STATS_EN
    logic [31:0]           mispredictCount;
    logic [31:0]           branchCount;

    modport master (
        output exValid, exIsBranch, exTaken, exTarget, exPc, exPredTaken, exPredTarget,
        output redirectReady,
        input  redirectValid, redirectPc, flush, stall, misalignValid, misalignPc,
        input  mispredictCount, branchCount
    );
    modport slave (
        input  exValid, exIsBranch, exTaken, exTarget, exPc, exPredTaken, exPredTarget,
        input  redirectReady,
        output redirectValid, redirectPc, flush, stall, misalignValid, misalignPc,
        output mispredictCount, branchCount
    );
`else
    modport master (
        output exValid, exIsBranch, exTaken, exTarget, exPc, exPredTaken, exPredTarget,
        output redirectReady,
        input  redirectValid, redirectPc, flush, stall, misalignValid, misalignPc
    );
    modport slave (
        input  exValid, exIsBranch, exTaken, exTarget, exPc, exPredTaken, exPredTarget,
        input  redirectReady,
        output redirectValid, redirectPc, flush, stall, misalignValid, misalignPc
    );
`endif
endinterface

// File: rtl/branch_redirect_controller.sv
// Front-end recovery sequencer: redirect fetch on a branch mispredict, then flush/stall for a drain window.
// Define BRANCH_STATS_EN to add the branch and mispredict counters.
module branch_redirect_controller #(
    parameter int DRAIN_CYCLES = 2,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    branch_redirect_controller_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t                state_q, state_d;
    logic [3:0]            drain_cnt_q, drain_cnt_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic                  redirect_valid_q;
    logic                  flush_q;
    logic                  stall_q;
    logic                  misalign_valid_q;
    logic [ADDR_WIDTH-1:0] misalign_pc_q, misalign_pc_d;

    logic                  resolve;
    logic                  fault;
    logic                  mispredict;
    logic [ADDR_WIDTH-1:0] recovery_pc;

    always_comb begin
        resolve     = bus.exValid && bus.exIsBranch && (state_q == IDLE);
        fault       = resolve && bus.exTaken && bus.exTarget[1];
        mispredict  = resolve && ((bus.exTaken != bus.exPredTaken) ||
                                  (bus.exTaken && (bus.exTarget != bus.exPredTarget)));
        recovery_pc = bus.exTaken ? bus.exTarget : (bus.exPc + ADDR_WIDTH'(4));
    end

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        redirect_pc_d = redirect_pc_q;
        misalign_pc_d = fault ? bus.exPc : misalign_pc_q;
        case (state_q)
            IDLE: begin
                // A misaligned taken target is reported instead of redirected
                if (mispredict && !fault) begin
                    state_d       = REDIRECT;
                    redirect_pc_d = recovery_pc;
                end
            end
            REDIRECT: begin
                if (bus.redirectReady) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            drain_cnt_q      <= '0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            misalign_valid_q <= 1'b0;
            misalign_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            drain_cnt_q      <= drain_cnt_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= (state_d == REDIRECT);
            flush_q          <= (state_d != IDLE);
            stall_q          <= (state_d != IDLE);
            misalign_valid_q <= fault;
            misalign_pc_q    <= misalign_pc_d;
        end
    end

    assign bus.redirectValid = redirect_valid_q;
    assign bus.redirectPc    = redirect_pc_q;
    assign bus.flush         = flush_q;
    assign bus.stall         = stall_q;
    assign bus.misalignValid = misalign_valid_q;
    assign bus.misalignPc    = misalign_pc_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (resolve) begin
                branch_count_q <= branch_count_q + 32'd1;
            end
            if (mispredict && !fault) begin
                mispredict_count_q <= mispredict_count_q + 32'd1;
            end
        end
    end

    assign bus.branchCount     = branch_count_q;
    assign bus.mispredictCount = mispredict_count_q;
`endif
endmodule

// File: tb/tb_branch_redirect_controller.sv
// Directed-vector bench for branch_redirect_controller (DRAIN_CYCLES=2, 32-bit addresses).
module tb_branch_redirect_controller;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    branch_redirect_controller_if #(.ADDR_WIDTH(32)) bus ();

    branch_redirect_controller #(
        .DRAIN_CYCLES (2),
        .ADDR_WIDTH   (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        bus.exValid      = 1'b0;
        bus.exIsBranch   = 1'b0;
        bus.exTaken      = 1'b0;
        bus.exTarget     = '0;
        bus.exPc         = '0;
        bus.exPredTaken  = 1'b0;
        bus.exPredTarget = '0;
    endtask

    task automatic drive_branch(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                                input logic pred_taken, input logic [31:0] pred_tgt);
        bus.exValid      = 1'b1;
        bus.exIsBranch   = 1'b1;
        bus.exPc         = pc;
        bus.exTaken      = taken;
        bus.exTarget     = tgt;
        bus.exPredTaken  = pred_taken;
        bus.exPredTarget = pred_tgt;
    endtask

    task automatic check_ctrl(input string tag, input logic rv, input logic fl, input logic st);
        check_eq({tag, ".redirectValid"}, 64'(bus.redirectValid), 64'(rv));
        check_eq({tag, ".flush"},         64'(bus.flush),         64'(fl));
        check_eq({tag, ".stall"},         64'(bus.stall),         64'(st));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        clear_ex();
        bus.redirectReady = 1'b1;
        tick();
        tick();
        check_ctrl("reset", 1'b0, 1'b0, 1'b0);
        check_eq("reset.misalignValid", 64'(bus.misalignValid), 64'h0);
        check_eq("reset.redirectPc",    64'(bus.redirectPc),    64'h0);
        check_eq("reset.misalignPc",    64'(bus.misalignPc),    64'h0);
        rst = 1'b0;
        tick();
        $display("txn reset: outputs idle");

        // Correct taken prediction: no activity
        drive_branch(32'h100, 1'b1, 32'h180, 1'b1, 32'h180);
        tick();
        clear_ex();
        check_ctrl("correct", 1'b0, 1'b0, 1'b0);
        check_eq("correct.misalignValid", 64'(bus.misalignValid), 64'h0);
        $display("txn correct-taken pc=0x100: no redirect");

        // Non-branch instruction with mismatched fields is ignored
        drive_branch(32'h140, 1'b1, 32'h500, 1'b0, 32'h0);
        bus.exIsBranch = 1'b0;
        tick();
        clear_ex();
        check_ctrl("nonbranch", 1'b0, 1'b0, 1'b0);
        $display("txn non-branch pc=0x140: ignored");

        // Direction mispredict, always-ready fetch; exValid replayed during recovery
        drive_branch(32'h200, 1'b0, 32'h300, 1'b1, 32'h300);
        tick();
        check_ctrl("dir.redirect", 1'b1, 1'b1, 1'b1);
        check_eq("dir.redirectPc", 64'(bus.redirectPc), 64'h204);
        tick();
        check_ctrl("dir.drain1", 1'b0, 1'b1, 1'b1);
        tick();
        check_ctrl("dir.drain2", 1'b0, 1'b1, 1'b1);
        tick();
        clear_ex();
        check_ctrl("dir.idle", 1'b0, 1'b0, 1'b0);
        tick();
        check_ctrl("dir.noreplay", 1'b0, 1'b0, 1'b0);
        $display("txn dir-mispredict pc=0x200: redirectPc=0x%0h", bus.redirectPc);

        // Target mispredict with 3 cycles of backpressure
        bus.redirectReady = 1'b0;
        drive_branch(32'h3F0, 1'b1, 32'h400, 1'b1, 32'h440);
        tick();
        clear_ex();
        for (int i = 0; i < 3; i++) begin
            check_ctrl($sformatf("tgt.hold%0d", i), 1'b1, 1'b1, 1'b1);
            check_eq($sformatf("tgt.hold%0d.redirectPc", i), 64'(bus.redirectPc), 64'h400);
            if (i == 1) drive_branch(32'h800, 1'b0, 32'h900, 1'b1, 32'h900);
            if (i == 2) bus.redirectReady = 1'b1;
            tick();
        end
        check_ctrl("tgt.drain1", 1'b0, 1'b1, 1'b1);
        tick();
        check_ctrl("tgt.drain2", 1'b0, 1'b1, 1'b1);
        clear_ex();
        tick();
        check_ctrl("tgt.idle", 1'b0, 1'b0, 1'b0);
        check_eq("tgt.redirectPc.kept", 64'(bus.redirectPc), 64'h400);
        $display("txn tgt-mispredict pc=0x3F0: redirectPc=0x400 after backpressure");

        // Misaligned taken target: fault wins over mispredict
        drive_branch(32'h2F0, 1'b1, 32'h302, 1'b0, 32'h0);
        tick();
        clear_ex();
        check_eq("mis.valid", 64'(bus.misalignValid), 64'h1);
        check_eq("mis.pc",    64'(bus.misalignPc),    64'h2F0);
        check_ctrl("mis", 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("mis.pulse", 64'(bus.misalignValid), 64'h0);
        check_ctrl("mis.after", 1'b0, 1'b0, 1'b0);
        $display("txn misaligned pc=0x2F0 target=0x302: fault reported");

        // PC wrap on not-taken recovery, then reset mid-redirect
        bus.redirectReady = 1'b0;
        drive_branch(32'hFFFF_FFFC, 1'b0, 32'h0000_1000, 1'b1, 32'h0000_1000);
        tick();
        clear_ex();
        check_ctrl("wrap.redirect", 1'b1, 1'b1, 1'b1);
        check_eq("wrap.redirectPc", 64'(bus.redirectPc), 64'h0);
        tick();
        check_ctrl("wrap.pending", 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.redirectReady = 1'b1;
        check_ctrl("wrap.rst", 1'b0, 1'b0, 1'b0);
        check_eq("wrap.rst.redirectPc", 64'(bus.redirectPc), 64'h0);
        tick();
        check_ctrl("wrap.abandoned", 1'b0, 1'b0, 1'b0);
        $display("txn wrap pc=0xFFFFFFFC: redirectPc=0, reset abandons redirect");

`ifdef BRANCH_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("stats.rst.branch", 64'(bus.branchCount),     64'h0);
        check_eq("stats.rst.mis",    64'(bus.mispredictCount), 64'h0);
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 5 || i == 8)
                drive_branch(32'h1000 + 32'(i * 16), 1'b0, 32'h2000, 1'b1, 32'h2000);
            else
                drive_branch(32'h1000 + 32'(i * 16), 1'b1, 32'h2000, 1'b1, 32'h2000);
            tick();
            clear_ex();
            for (int w = 0; w < 10 && bus.stall; w++) tick();
            check_eq($sformatf("stats.recover%0d", i), 64'(bus.stall), 64'h0);
        end
        check_eq("stats.branch", 64'(bus.branchCount),     64'd10);
        check_eq("stats.mis",    64'(bus.mispredictCount), 64'd3);
        $display("txn stats: branchCount=%0d mispredictCount=%0d", bus.branchCount, bus.mispredictCount);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
